// File: rtl/div_request_control_if.sv
// div_request_control_if
//   Bundles the request/response handshake and the unsigned divider core
//   handshake for div_request_control.
//
//   Request side : req_valid, req_ready, req_op, req_rs1, req_rs2
//   Response side: resp_valid, resp_data
//   Core side    : core_start, core_ready, core_valid, core_error,
//                  core_dividend, core_divisor, core_quotient, core_remainder
//
//   Modports:
//     slave  - the div_request_control block itself
//     master - the surrounding environment (requester plus divider core)
interface div_request_control_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;

    logic            resp_valid;
    logic [XLEN-1:0] resp_data;

    logic            core_start;
    logic            core_ready;
    logic            core_valid;
    logic            core_error;
    logic [XLEN-1:0] core_dividend;
    logic [XLEN-1:0] core_divisor;
    logic [XLEN-1:0] core_quotient;
    logic [XLEN-1:0] core_remainder;

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_rs1,
        input  req_rs2,
        input  core_ready,
        input  core_valid,
        input  core_error,
        input  core_quotient,
        input  core_remainder,
        output req_ready,
        output resp_valid,
        output resp_data,
        output core_start,
        output core_dividend,
        output core_divisor
    );

    modport master (
        output req_valid,
        output req_op,
        output req_rs1,
        output req_rs2,
        output core_ready,
        output core_valid,
        output core_error,
        output core_quotient,
        output core_remainder,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  core_start,
        input  core_dividend,
        input  core_divisor
    );
endinterface

// File: rtl/div_request_control.sv
// div_request_control
//   Front end for the multi-cycle unsigned divider core in the M-extension
//   execute path. Takes DIV/DIVU/REM/REMU requests, answers divide-by-zero
//   and signed overflow locally, and otherwise feeds operand magnitudes to
//   the core and re-applies the result sign.
//
//   Ports:
//     clk    - clock
//     reset  - asynchronous, active-high reset
//     bus    - div_request_control_if.slave
//              req_valid/req_ready/req_op/req_rs1/req_rs2 : request
//              resp_valid/resp_data                       : one-cycle response
//              core_start/core_ready/core_valid/...       : divider core
//
//   req_op encoding: 00=DIV, 01=DIVU, 10=REM, 11=REMU
module div_request_control #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    div_request_control_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t          state;
    logic [1:0]      op_q;
    logic            q_neg;
    logic            r_neg;

    logic            req_signed;
    logic            req_rem;
    logic            div_by_zero;
    logic            overflow;
    logic            rs1_neg;
    logic            rs2_neg;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] core_result;

    // The core never sees a zero divisor from this block, so its error
    // flag carries no information here.
    logic            unused_core_error;
    assign unused_core_error = bus.core_error;

    // Handshake outputs follow directly from the state register.
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.core_start = (state == ISSUE);

    // Request decode: the two locally answered cases and the operand
    // magnitudes for the core. The negate of MIN_INT wraps back to itself,
    // which is exactly 2^(XLEN-1) when read as unsigned.
    always_comb begin
        req_signed     = ~bus.req_op[0];
        req_rem        = bus.req_op[1];
        div_by_zero    = (bus.req_rs2 == '0);
        overflow       = req_signed && (bus.req_rs1 == MIN_INT) &&
                         (bus.req_rs2 == ALL_ONES);
        rs1_neg        = req_signed & bus.req_rs1[XLEN-1];
        rs2_neg        = req_signed & bus.req_rs2[XLEN-1];
        rs1_mag        = rs1_neg ? (~bus.req_rs1 + 1'b1) : bus.req_rs1;
        rs2_mag        = rs2_neg ? (~bus.req_rs2 + 1'b1) : bus.req_rs2;
        special_result = '0;
        if (div_by_zero) begin
            special_result = req_rem ? bus.req_rs1 : ALL_ONES;
        end else begin
            special_result = req_rem ? '0 : bus.req_rs1;
        end
    end

    // Sign restoration of the core result for the latched operation.
    always_comb begin
        core_result = bus.core_remainder;
        case (op_q)
            OP_DIV:  core_result = q_neg ? (~bus.core_quotient + 1'b1)
                                         : bus.core_quotient;
            OP_DIVU: core_result = bus.core_quotient;
            OP_REM:  core_result = r_neg ? (~bus.core_remainder + 1'b1)
                                         : bus.core_remainder;
            OP_REMU: core_result = bus.core_remainder;
            default: core_result = bus.core_remainder;
        endcase
    end

    // Request sequencing. A reset while the core is busy simply drops the
    // request; the next one parks in ISSUE until the core reports ready,
    // which only happens after the core has flushed its stale result, so
    // that stale core_valid is never seen in WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            op_q              <= OP_DIV;
            q_neg             <= 1'b0;
            r_neg             <= 1'b0;
            bus.resp_data     <= '0;
            bus.core_dividend <= '0;
            bus.core_divisor  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q <= bus.req_op;
                        if (div_by_zero || overflow) begin
                            q_neg         <= 1'b0;
                            r_neg         <= 1'b0;
                            bus.resp_data <= special_result;
                            state         <= RESP;
                        end else begin
                            q_neg             <= rs1_neg ^ rs2_neg;
                            r_neg             <= rs1_neg;
                            bus.core_dividend <= rs1_mag;
                            bus.core_divisor  <= rs2_mag;
                            state             <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.core_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.core_valid) begin
                        bus.resp_data <= core_result;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_request_control.sv
// tb_div_request_control
//   Directed bench for div_request_control. Stimulus pushes expected
//   responses into a scoreboard; a monitor pops and compares them whenever
//   resp_valid is seen. A small behavioural unsigned divider stands in for
//   the core, with adjustable latency and a forced not-ready window.
module tb_div_request_control;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        logic [31:0] data;
        bit          special;
        int          start_cycles;
        int          starts;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        string       name;
    } ops_t;

    logic clk;
    logic reset;

    div_request_control_if #(.XLEN(XLEN)) bus ();

    div_request_control #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   resp_count = 0;
    int   exp_resps  = 0;

    exp_t sb[$];
    ops_t op_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Behavioural divider core: samples operands on a start handshake,
    // pulses core_valid after core_lat cycles, and reports ready again only
    // in the cycle after that pulse.
    logic        busy       = 1'b0;
    int          cnt        = 0;
    int          core_lat   = 4;
    logic        stall_hold = 1'b0;
    logic        take_n     = 1'b0;
    logic [31:0] a_n        = '0;
    logic [31:0] b_n        = '0;
    ops_t        ops_e;

    assign bus.core_ready = !busy && !stall_hold;

    always @(negedge clk) begin
        take_n = 1'b0;
        if (!reset && bus.core_start === 1'b1 && bus.core_ready === 1'b1) begin
            take_n = 1'b1;
            a_n    = bus.core_dividend;
            b_n    = bus.core_divisor;
            if (op_q.size() == 0) begin
                check_output("unexpected core start", 32'd1, 32'd0);
            end else begin
                ops_e = op_q.pop_front();
                check_output({ops_e.name, " core_dividend"}, bus.core_dividend, ops_e.a);
                check_output({ops_e.name, " core_divisor"}, bus.core_divisor, ops_e.b);
            end
        end
    end

    always @(posedge clk) begin
        bus.core_valid <= 1'b0;
        if (take_n) begin
            busy <= 1'b1;
            cnt  <= core_lat;
            bus.core_quotient  <= (b_n != 0) ? a_n / b_n : 32'hFFFF_FFFF;
            bus.core_remainder <= (b_n != 0) ? a_n % b_n : a_n;
        end else if (busy) begin
            if (cnt == 0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1;
                if (cnt == 1) bus.core_valid <= 1'b1;
            end
        end
    end

    // Response monitor: compares data, latency, pulse width and how the
    // core handshake was used for each response.
    int   start_seen = 0;
    int   start_hi   = 0;
    int   last_cv    = 0;
    int   accept_cyc = 0;
    logic prev_resp  = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (reset) begin
            start_seen = 0;
            start_hi   = 0;
            prev_resp  = 1'b0;
        end else begin
            if (bus.core_start === 1'b1) start_hi++;
            if (bus.core_start === 1'b1 && bus.core_ready === 1'b1) start_seen++;
            if (bus.core_valid === 1'b1) last_cv = cyc;
            if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) accept_cyc = cyc + 1;
            if (bus.resp_valid === 1'b1) begin
                resp_count++;
                check_output("resp_valid one-cycle pulse", {31'd0, prev_resp}, 32'd0);
                if (sb.size() == 0) begin
                    check_output("unexpected response", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_output({e.name, " resp_data"}, bus.resp_data, e.data);
                    check_output({e.name, " core starts"}, 32'(start_seen), 32'(e.starts));
                    if (e.start_cycles >= 0)
                        check_output({e.name, " core_start cycles"}, 32'(start_hi),
                                     32'(e.start_cycles));
                    if (e.special)
                        check_output({e.name, " latency from accept"}, 32'(cyc),
                                     32'(accept_cyc));
                    else
                        check_output({e.name, " latency from core_valid"}, 32'(cyc),
                                     32'(last_cv + 1));
                end
                start_seen = 0;
                start_hi   = 0;
            end
            prev_resp = bus.resp_valid;
        end
    end

    // Pushes the expectation, then holds the request until accepted.
    task automatic apply_stimulus(input string name, input logic [1:0] op,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] exp_data, input bit special,
                                  input int start_cycles,
                                  input logic [31:0] exp_a, input logic [31:0] exp_b);
        exp_t ne;
        ops_t no;
        bit   accepted;
        ne.data         = exp_data;
        ne.special      = special;
        ne.start_cycles = start_cycles;
        ne.starts       = special ? 0 : 1;
        ne.name         = name;
        sb.push_back(ne);
        exp_resps++;
        if (!special) begin
            no.a    = exp_a;
            no.b    = exp_b;
            no.name = name;
            op_q.push_back(no);
        end
        @(posedge clk); #2;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        accepted      = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = (bus.req_ready === 1'b1);
            @(posedge clk); #2;
        end
        bus.req_valid = 1'b0;
        check_output({name, " accepted"}, {31'd0, accepted}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        check_output("scoreboard drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic run(input string name, input logic [1:0] op,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] exp_data, input bit special,
                       input logic [31:0] exp_a, input logic [31:0] exp_b);
        apply_stimulus(name, op, rs1, rs2, exp_data, special, special ? 0 : 1,
                       exp_a, exp_b);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_op      = OP_DIV;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.core_error  = 1'b0;

        repeat (3) @(negedge clk);
        check_output("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_output("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_output("reset resp_data", bus.resp_data, 32'd0);
        check_output("reset core_start", {31'd0, bus.core_start}, 32'd0);
        check_output("reset core_dividend", bus.core_dividend, 32'd0);
        check_output("reset core_divisor", bus.core_divisor, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        $display("[TB] signed divide/remainder through the core");
        run("DIV -7/2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 32'd7, 32'd2);
        run("REM -7/2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 32'd7, 32'd2);
        run("DIV 7/-2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'd7, 32'd2);
        run("REM 7/-2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 32'd7, 32'd2);
        run("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 32'd100, 32'd7);
        run("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 32'd100, 32'd7);
        run("DIVU MIN/-1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0,
            32'h8000_0000, 32'hFFFF_FFFF);
        run("REMU MIN/-1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0,
            32'h8000_0000, 32'hFFFF_FFFF);

        $display("[TB] divide by zero and signed overflow");
        run("DIVU x/0",   OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0);
        run("REM x/0",    OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 32'd0, 32'd0);
        run("DIV -5/0",   OP_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0);
        run("DIV MIN/-1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1,
            32'd0, 32'd0);
        run("REM MIN/-1", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 32'd0);

        $display("[TB] core not ready for five cycles");
        stall_hold = 1'b1;
        apply_stimulus("DIV MIN/2 stalled", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000,
                       1'b0, 6, 32'h8000_0000, 32'd2);
        repeat (5) @(posedge clk);
        #2;
        stall_hold = 1'b0;
        wait_drain();

        $display("[TB] reset while waiting on the core");
        core_lat = 10;
        apply_stimulus("DIVU 50/5 abandoned", OP_DIVU, 32'd50, 32'd5, 32'd10, 1'b0, -1,
                       32'd50, 32'd5);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        exp_resps--;
        @(posedge clk); #2;
        reset = 1'b0;
        check_output("post-reset req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_output("post-reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check_output("post-reset core_start", {31'd0, bus.core_start}, 32'd0);
        core_lat = 4;
        apply_stimulus("DIVU 9/3 after reset", OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, -1,
                       32'd9, 32'd3);
        wait_drain();
        repeat (20) @(posedge clk);

        check_output("total responses", 32'(resp_count), 32'(exp_resps));
        check_output("core operand queue drained", 32'(op_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_request_control.md
Name: div_request_control

Overview:
- Request/sign-handling stage directly upstream of the team's multi-cycle unsigned divider core in the M-extension execute path.
- Accepts RISC-V DIV/DIVU/REM/REMU requests and resolves the divide-by-zero and signed-overflow cases locally, without using the core.
- Otherwise converts operands to magnitudes, drives the core's start/ready/valid handshake, and restores the result sign.
- Returns one XLEN-bit result per request.

Parameters:
XLEN, 32, operand/result width; must equal the SIZE of the attached unsigned divider core.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
req_rs1  in  XLEN  dividend
req_rs2  in  XLEN  divisor
resp_valid  out  1  one-cycle result pulse
resp_data  out  XLEN  result, held until next response
core_start  out  1  start strobe to unsigned divider core
core_ready  in  1  core idle
core_valid  in  1  core result available
core_error  in  1  core divide-by-zero flag (unused; never expected)
core_dividend  out  XLEN  unsigned magnitude of dividend
core_divisor  out  XLEN  unsigned magnitude of divisor
core_quotient  in  XLEN  core quotient
core_remainder  in  XLEN  core remainder

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, core_start=0, core_dividend=0, core_divisor=0, internal sign/op flags=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, then choose one of the following:
    - rs2==0: result = all-ones for DIV/DIVU, rs1 for REM/REMU; go to RESP; core untouched.
    - op==DIV/REM, rs1==1<<(XLEN-1), rs2==all-ones: result = rs1 for DIV, 0 for REM; go to RESP; core untouched.
    - Otherwise:
      - signed ops: core_dividend=|rs1|, core_divisor=|rs2| (two's-complement negate if MSB set; |MIN| = 2^(XLEN-1) as unsigned).
      - unsigned ops: operands passed through unchanged.
      - q_neg = rs1[MSB]^rs2[MSB]; r_neg = rs1[MSB]; both forced 0 for unsigned ops.
      - go to ISSUE.
- ISSUE:
  - core_start is combinational, = (state==ISSUE).
  - Move to WAIT in the first cycle where core_ready=1; the core samples start in that cycle.
  - Stay in ISSUE while core_ready=0.
- WAIT:
  - On the first cycle core_valid=1, capture the result:
    - DIV: q_neg ? -core_quotient : core_quotient.
    - DIVU: core_quotient.
    - REM: r_neg ? -core_remainder : core_remainder.
    - REMU: core_remainder.
  - Result is registered into resp_data; go to RESP.
  - core_error is ignored; the core result is taken as-is.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. resp_data holds its value afterwards.
- Latency:
  - Special cases: request accepted at edge T, resp_valid high in cycle T+1.
  - Normal path: accept at T, core_start high from T+1. If the core is ready then, the core starts at T+1. With core_valid first high in cycle V, resp_valid is high in cycle V+1.
- No back-pressure on the response; the consumer must take resp_data in the resp_valid cycle.
- Only one request outstanding. req_valid while req_ready=0 is ignored, not queued.
- Reset mid-operation:
  - The request is abandoned and no response is generated.
  - The core may still be busy. The next request waits in ISSUE until core_ready=1, and the core only returns to ready after its stale result. A stale core_valid is therefore never captured.
- All arithmetic is modulo 2^XLEN. Negation is two's complement.

Test Plan:
1. DIV rs1=0xFFFFFFF9 (-7), rs2=2, core returns q=3 r=1 -> core_dividend=7, core_divisor=2, resp_data=0xFFFFFFFD.
2. REM rs1=0xFFFFFFF9, rs2=2 -> resp_data=0xFFFFFFFF; REMU rs1=100, rs2=7 -> resp_data=2; DIVU 100/7 -> resp_data=14.
3. DIVU rs1=0x12345678, rs2=0 -> resp_data=0xFFFFFFFF one cycle after accept, core_start never asserted; REM same operands -> resp_data=0x12345678.
4. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> resp_data=0x80000000; REM same -> 0; neither asserts core_start.
5. DIV rs1=0x80000000, rs2=2 -> core_dividend=0x80000000, resp_data=0xC0000000. Hold core_ready=0 for 5 cycles before this request's start: core_start held high throughout, WAIT entered only after core_ready rises.
6. Assert reset during WAIT, then issue DIVU 9/3 while the core is still busy -> first core_valid (stale) ignored, resp_data=3 for the new request, exactly one resp_valid pulse.
